exe_result_stage: RTL and testbench

- Execute-to-writeback boundary stage. Consumes the shifter's left/right results, the ALU result and the link address for each executed instruction.
- Selects the final result and buffers it in a 2-entry skid FIFO with valid/ready handshakes on both sides.
- Presents the head entry to the register-file writeback port and as a forwarding source back to decode.
- Keeps a retired-instruction counter.

---
 rtl/exe_pkg.sv | 22 ++
 rtl/skid_fifo2.sv | 63 ++++++
 rtl/exe_result_stage.sv | 113 +++++++++++
 tb/tb_exe_result_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared types for the execute result stage.
//   res_sel_t   : which execute-unit result becomes the instruction's result
//   exe_entry_t : one buffered writeback entry (value, pc, rd index, rd write enable)
package exe_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    RES_ALU  = 2'd0,
    RES_SHL  = 2'd1,
    RES_SHR  = 2'd2,
    RES_LINK = 2'd3
  } res_sel_t;

  typedef struct packed {
    logic [XLEN-1:0] value;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd_idx;
    logic            rd_we;
  } exe_entry_t;

endpackage

// File: rtl/skid_fifo2.sv
// Generic 2-entry valid/ready FIFO with flush.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   flush               : empties the FIFO next cycle; a push in the same cycle is dropped
//   in_valid/in_ready   : producer handshake; in_ready depends only on registered state and rst_n
//   in_data             : payload written on a push
//   out_valid/out_ready : consumer handshake on the head entry
//   out_data            : head payload, forced to 0 while the FIFO is empty or held in reset
module skid_fifo2 #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  // Masking by rst_n keeps any handshake from completing in a reset cycle.
  assign in_ready  = rst_n && (count < 2'(DEPTH));
  assign out_valid = rst_n && (count != 2'd0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; out_data masking hides stale contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/exe_result_stage.sv
// Execute-to-writeback boundary stage.
// Selects the final result (ALU, shift left, shift right or link address), buffers it
// in a 2-entry FIFO and presents the head to the register-file writeback port and to
// decode as a forwarding source. Counts retired (popped) instructions.
// Ports:
//   clk, rst_n                   : clock, synchronous active-low reset
//   ex_valid_i/ex_ready_o        : execute-side handshake
//   ex_res_sel_i                 : result select (res_sel_t encoding)
//   ex_rd_idx_i, ex_rd_we_i      : destination register and its write enable
//   ex_pc_i                      : instruction PC
//   alu_result_i, sh_left_w, sh_right_w : candidate results
//   ex_flush_i                   : drop buffered and incoming entries
//   wb_valid_o/wb_ready_i        : writeback-side handshake
//   wb_rd_idx_o, wb_rd_we_o, wb_value_o, wb_pc_o : head entry
//   fwd_valid_o, fwd_idx_o, fwd_value_o          : forwarding view of the head
//   retire_cnt_o                 : number of completed writeback handshakes
module exe_result_stage #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic [1:0]      ex_res_sel_i,
  input  logic [4:0]      ex_rd_idx_i,
  input  logic            ex_rd_we_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [XLEN-1:0] sh_left_w,
  input  logic [XLEN-1:0] sh_right_w,
  input  logic            ex_flush_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [4:0]      wb_rd_idx_o,
  output logic            wb_rd_we_o,
  output logic [XLEN-1:0] wb_value_o,
  output logic [XLEN-1:0] wb_pc_o,
  output logic            fwd_valid_o,
  output logic [4:0]      fwd_idx_o,
  output logic [XLEN-1:0] fwd_value_o,
  output logic [31:0]     retire_cnt_o
);

  import exe_pkg::*;

  res_sel_t        res_sel;
  logic [XLEN-1:0] result;
  exe_entry_t      push_entry;
  exe_entry_t      head;
  logic [$bits(exe_entry_t)-1:0] head_bits;
  logic            pop;
  logic [31:0]     retire_cnt_q;

  assign res_sel = res_sel_t'(ex_res_sel_i);

  // Only the selected value is stored; the link address wraps modulo 2^XLEN.
  always_comb begin
    result = alu_result_i;
    case (res_sel)
      RES_ALU:  result = alu_result_i;
      RES_SHL:  result = sh_left_w;
      RES_SHR:  result = sh_right_w;
      RES_LINK: result = ex_pc_i + XLEN'(4);
      default:  result = alu_result_i;
    endcase
  end

  // x0 is never written, so its write enable is dropped before buffering.
  always_comb begin
    push_entry        = '0;
    push_entry.value  = result;
    push_entry.pc     = ex_pc_i;
    push_entry.rd_idx = ex_rd_idx_i;
    push_entry.rd_we  = ex_rd_we_i && (ex_rd_idx_i != 5'd0);
  end

  skid_fifo2 #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(exe_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (ex_flush_i),
    .in_valid  (ex_valid_i),
    .in_ready  (ex_ready_o),
    .in_data   (push_entry),
    .out_valid (wb_valid_o),
    .out_ready (wb_ready_i),
    .out_data  (head_bits)
  );

  assign head = exe_entry_t'(head_bits);

  assign wb_rd_idx_o = head.rd_idx;
  assign wb_rd_we_o  = head.rd_we;
  assign wb_value_o  = head.value;
  assign wb_pc_o     = head.pc;
  assign fwd_valid_o = wb_valid_o && head.rd_we;
  assign fwd_idx_o   = head.rd_idx;
  assign fwd_value_o = head.value;

  // A pop during a flush still retires, so the counter ignores flush.
  assign pop = wb_valid_o && wb_ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) retire_cnt_q <= 32'd0;
    else if (pop) retire_cnt_q <= retire_cnt_q + 32'd1;
  end

  assign retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_exe_result_stage.sv
// Directed self-checking bench for exe_result_stage.
module tb_exe_result_stage;

  logic        clk;
  logic        rst_n;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [1:0]  ex_res_sel_i;
  logic [4:0]  ex_rd_idx_i;
  logic        ex_rd_we_i;
  logic [31:0] ex_pc_i;
  logic [31:0] alu_result_i;
  logic [31:0] sh_left_w;
  logic [31:0] sh_right_w;
  logic        ex_flush_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [4:0]  wb_rd_idx_o;
  logic        wb_rd_we_o;
  logic [31:0] wb_value_o;
  logic [31:0] wb_pc_o;
  logic        fwd_valid_o;
  logic [4:0]  fwd_idx_o;
  logic [31:0] fwd_value_o;
  logic [31:0] retire_cnt_o;

  int checks;
  int failures;
  logic [31:0] exp_retire;

  exe_result_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid_i   (ex_valid_i),
    .ex_ready_o   (ex_ready_o),
    .ex_res_sel_i (ex_res_sel_i),
    .ex_rd_idx_i  (ex_rd_idx_i),
    .ex_rd_we_i   (ex_rd_we_i),
    .ex_pc_i      (ex_pc_i),
    .alu_result_i (alu_result_i),
    .sh_left_w    (sh_left_w),
    .sh_right_w   (sh_right_w),
    .ex_flush_i   (ex_flush_i),
    .wb_valid_o   (wb_valid_o),
    .wb_ready_i   (wb_ready_i),
    .wb_rd_idx_o  (wb_rd_idx_o),
    .wb_rd_we_o   (wb_rd_we_o),
    .wb_value_o   (wb_value_o),
    .wb_pc_o      (wb_pc_o),
    .fwd_valid_o  (fwd_valid_o),
    .fwd_idx_o    (fwd_idx_o),
    .fwd_value_o  (fwd_value_o),
    .retire_cnt_o (retire_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [1:0] sel, input logic [4:0] rd,
                       input logic we, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] shl, input logic [31:0] shr);
    ex_valid_i   = valid;
    ex_res_sel_i = sel;
    ex_rd_idx_i  = rd;
    ex_rd_we_i   = we;
    ex_pc_i      = pc;
    alu_result_i = alu;
    sh_left_w    = shl;
    sh_right_w   = shr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_wb_valid got=%b exp=0", wb_valid_o); end
    checks++; if (ex_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_ex_ready got=%b exp=0", ex_ready_o); end
    checks++; if (retire_cnt_o !== 32'd0) begin failures++; $display("[TB] FAIL reset_retire got=%h exp=0", retire_cnt_o); end
    checks++; if (wb_value_o !== 32'd0 || fwd_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_outputs value=%h fwd_valid=%b exp=0/0", wb_value_o, fwd_valid_o); end
    rst_n = 1'b1;
    #1;
    checks++; if (ex_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_ready got=%b exp=1", ex_ready_o); end
    exp_retire = 32'd0;
  endtask

  task automatic test_single_push();
    wb_ready_i = 1'b1;
    drive(1'b1, 2'd1, 5'd5, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0F00, 32'h1234_5678);
    #1;
    checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL no_comb_path got=%b exp=0", wb_valid_o); end
    tick();
    drive(1'b0, 2'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    checks++; if (wb_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL single_valid got=%b exp=1", wb_valid_o); end
    checks++; if (wb_value_o !== 32'h0000_0F00) begin failures++; $display("[TB] FAIL single_value got=%h exp=00000f00", wb_value_o); end
    checks++; if (fwd_valid_o !== 1'b1 || fwd_idx_o !== 5'd5 || fwd_value_o !== 32'h0000_0F00) begin failures++; $display("[TB] FAIL single_fwd valid=%b idx=%0d val=%h exp=1/5/00000f00", fwd_valid_o, fwd_idx_o, fwd_value_o); end
    checks++; if (wb_pc_o !== 32'h0000_0100 || wb_rd_idx_o !== 5'd5 || wb_rd_we_o !== 1'b1) begin failures++; $display("[TB] FAIL single_fields pc=%h rd=%0d we=%b exp=00000100/5/1", wb_pc_o, wb_rd_idx_o, wb_rd_we_o); end
    tick();
    exp_retire = exp_retire + 1;
    checks++; if (retire_cnt_o !== exp_retire) begin failures++; $display("[TB] FAIL single_retire got=%0d exp=%0d", retire_cnt_o, exp_retire); end
    checks++; if (wb_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL single_empty got=%b exp=0", wb_valid_o); end
  endtask

  task automatic test_link_x0();
    wb_ready_i = 1'b0;
    drive(1'b1, 2'd3, 5'd0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0123, 32'h0000_0456, 32'h0000_0789);
    tick();
    drive(1'b0, 2'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    checks++; if (wb_valid_o !== 1'b1 || wb_value_o !== 32'h0000_0000) begin failures++; $display("[TB] FAIL link_wrap valid=%b value=%h exp=1/00000000", wb_valid_o, wb_value_o); end
    checks++; if (wb_rd_we_o !== 1'b0 || fwd_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL x0_suppress we=%b fwd_valid=%b exp=0/0", wb_rd_we_o, fwd_valid_o); end
    checks++; if (wb_pc_o !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL link_pc got=%h exp=fffffffc", wb_pc_o); end
    wb_ready_i = 1'b1;
    tick();
    exp_retire = exp_retire + 1;
    checks++; if (retire_cnt_o !== exp_retire) begin failures++; $display("[TB] FAIL link_retire got=%0d exp=%0d", retire_cnt_o, exp_retire); end
  endtask

  task automatic test_backpressure();
    wb_ready_i = 1'b0;
    drive(1'b1, 2'd0, 5'd1, 1'b1, 32'h0000_1000, 32'h1111_1111, 32'hAAAA_0000, 32'hBBBB_0000);
    tick();
    drive(1'b1, 2'd2, 5'd2, 1'b1, 32'h0000_1004, 32'hCCCC_0000, 32'hAAAA_0001, 32'h2222_2222);
    tick();
    checks++; if (ex_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL full_ready got=%b exp=0", ex_ready_o); end
    drive(1'b1, 2'd0, 5'd3, 1'b1, 32'h0000_1008, 32'h3333_3333, 32'hAAAA_0002, 32'hBBBB_0002);
    tick();
    tick();
    checks++; if (ex_ready_o !== 1'b0 || wb_value_o !== 32'h1111_1111) begin failures++; $display("[TB] FAIL held_full ready=%b head=%h exp=0/11111111", ex_ready_o, wb_value_o); end
    wb_ready_i = 1'b1;
    tick();
    checks++; if (wb_value_o !== 32'h2222_2222 || wb_rd_idx_o !== 5'd2 || ex_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL drain_second head=%h rd=%0d ready=%b exp=22222222/2/1", wb_value_o, wb_rd_idx_o, ex_ready_o); end
    tick();
    drive(1'b0, 2'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    checks++; if (wb_valid_o !== 1'b1 || wb_value_o !== 32'h3333_3333 || wb_pc_o !== 32'h0000_1008) begin failures++; $display("[TB] FAIL drain_third valid=%b head=%h pc=%h exp=1/33333333/00001008", wb_valid_o, wb_value_o, wb_pc_o); end
    tick();
    exp_retire = exp_retire + 3;
    checks++; if (wb_valid_o !== 1'b0 || retire_cnt_o !== exp_retire) begin failures++; $display("[TB] FAIL drain_done valid=%b retire=%0d exp=0/%0d", wb_valid_o, retire_cnt_o, exp_retire); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    int bad;
    bad = 0;
    wb_ready_i = 1'b0;
    drive(1'b1, 2'd0, 5'd7, 1'b1, 32'h0000_2000, 32'h5000_0000, 32'd0, 32'd0);
    tick();
    wb_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      v = 32'h5000_0001 + 32'(k);
      drive(1'b1, 2'd0, 5'd7, 1'b1, 32'h0000_2000, v, 32'd0, 32'd0);
      #1;
      if (ex_ready_o !== 1'b1) bad++;
      tick();
      if (wb_valid_o !== 1'b1 || wb_value_o !== v) bad++;
    end
    drive(1'b0, 2'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    exp_retire = exp_retire + 10;
    checks++; if (bad != 0) begin failures++; $display("[TB] FAIL b2b_stream bad_cycles=%0d exp=0", bad); end
    checks++; if (retire_cnt_o !== exp_retire) begin failures++; $display("[TB] FAIL b2b_retire got=%0d exp=%0d", retire_cnt_o, exp_retire); end
  endtask

  task automatic test_flush();
    wb_ready_i = 1'b0;
    drive(1'b1, 2'd1, 5'd8, 1'b1, 32'h0000_3000, 32'd0, 32'h6000_0000, 32'd0);
    tick();
    checks++; if (ex_ready_o !== 1'b0 || wb_value_o !== 32'h5000_000A) begin failures++; $display("[TB] FAIL preflush ready=%b head=%h exp=0/5000000a", ex_ready_o, wb_value_o); end
    drive(1'b1, 2'd0, 5'd9, 1'b1, 32'h0000_3004, 32'h7000_0000, 32'd0, 32'd0);
    ex_flush_i = 1'b1;
    wb_ready_i = 1'b1;
    tick();
    ex_flush_i = 1'b0;
    drive(1'b0, 2'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    exp_retire = exp_retire + 1;
    checks++; if (retire_cnt_o !== exp_retire) begin failures++; $display("[TB] FAIL flush_retire got=%0d exp=%0d", retire_cnt_o, exp_retire); end
    checks++; if (wb_valid_o !== 1'b0 || ex_ready_o !== 1'b1) begin failures++; $display("[TB] FAIL flush_empty valid=%b ready=%b exp=0/1", wb_valid_o, ex_ready_o); end
    tick();
    checks++; if (wb_valid_o !== 1'b0 || retire_cnt_o !== exp_retire) begin failures++; $display("[TB] FAIL flush_stays valid=%b retire=%0d exp=0/%0d", wb_valid_o, retire_cnt_o, exp_retire); end
  endtask

  task automatic test_retire_wrap();
    wb_ready_i = 1'b0;
    drive(1'b1, 2'd0, 5'd4, 1'b1, 32'h0000_4000, 32'h0BAD_F00D, 32'd0, 32'd0);
    tick();
    drive(1'b0, 2'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    #1;
    checks++; if (retire_cnt_o !== 32'hFFFF_FFFF) begin failures++; $display("[TB] FAIL wrap_preload got=%h exp=ffffffff", retire_cnt_o); end
    wb_ready_i = 1'b1;
    tick();
    exp_retire = 32'd0;
    checks++; if (retire_cnt_o !== exp_retire) begin failures++; $display("[TB] FAIL wrap_retire got=%h exp=00000000", retire_cnt_o); end
  endtask

  task automatic test_reset_mid();
    wb_ready_i = 1'b0;
    drive(1'b1, 2'd0, 5'd10, 1'b1, 32'h0000_5000, 32'h8000_0001, 32'd0, 32'd0);
    tick();
    drive(1'b1, 2'd0, 5'd11, 1'b1, 32'h0000_5004, 32'h8000_0002, 32'd0, 32'd0);
    tick();
    rst_n = 1'b0;
    wb_ready_i = 1'b1;
    #1;
    checks++; if (wb_valid_o !== 1'b0 || ex_ready_o !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_comb valid=%b ready=%b exp=0/0", wb_valid_o, ex_ready_o); end
    checks++; if (wb_value_o !== 32'd0 || fwd_valid_o !== 1'b0 || wb_pc_o !== 32'd0) begin failures++; $display("[TB] FAIL mid_reset_mask value=%h fwd=%b pc=%h exp=0/0/0", wb_value_o, fwd_valid_o, wb_pc_o); end
    tick();
    rst_n = 1'b1;
    drive(1'b0, 2'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    #1;
    checks++; if (wb_valid_o !== 1'b0 || ex_ready_o !== 1'b1 || retire_cnt_o !== 32'd0) begin failures++; $display("[TB] FAIL after_mid_reset valid=%b ready=%b retire=%0d exp=0/1/0", wb_valid_o, ex_ready_o, retire_cnt_o); end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    exp_retire = 32'd0;
    rst_n      = 1'b0;
    ex_flush_i = 1'b0;
    wb_ready_i = 1'b0;
    drive(1'b0, 2'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    test_reset();
    test_single_push();
    test_link_x0();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_retire_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "[TB] timeout");
  end

endmodule
